// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: STAGES slices of WIDTH/STAGES bits, carry registered between slices,
// valid/ready handshake with full backpressure. Define PIPELINED_ADDER_OVF_EN to add the out_ovf port.
module pipelined_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout
`ifdef PIPELINED_ADDER_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int SW = WIDTH / STAGES;

   logic advance;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         localparam int DONE = (gi + 1) * SW;
         localparam int REM  = WIDTH - DONE;

         logic [SW-1:0]   a_s;
         logic [SW-1:0]   b_s;
         logic            c_s;
         logic            v_s;
         logic [SW:0]     slice_sum;
         logic [DONE-1:0] sum_next;
         logic            valid_reg;
         logic            carry_reg;
         logic [DONE-1:0] sum_reg;

         // Stage 0 works on the live inputs; later stages on the skewed operand bits of their predecessor.
         if (gi == 0) begin : g_first
            assign a_s      = in_a[SW-1:0];
            assign b_s      = in_b[SW-1:0];
            assign c_s      = in_cin;
            assign v_s      = in_valid;
            assign sum_next = slice_sum[SW-1:0];
         end else begin : g_next
            assign a_s      = g_stage[gi-1].g_skew.a_reg[SW-1:0];
            assign b_s      = g_stage[gi-1].g_skew.b_reg[SW-1:0];
            assign c_s      = g_stage[gi-1].carry_reg;
            assign v_s      = g_stage[gi-1].valid_reg;
            assign sum_next = {slice_sum[SW-1:0], g_stage[gi-1].sum_reg};
         end

         assign slice_sum = {1'b0, a_s} + {1'b0, b_s} + {{SW{1'b0}}, c_s};

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               valid_reg <= 1'b0;
               carry_reg <= 1'b0;
               sum_reg   <= '0;
            end else if (advance) begin
               valid_reg <= v_s;
               carry_reg <= slice_sum[SW];
               sum_reg   <= sum_next;
            end
         end

         // Operand bits not yet consumed travel alongside the partial sum.
         if (REM > 0) begin : g_skew
            logic [REM-1:0] a_next;
            logic [REM-1:0] b_next;
            logic [REM-1:0] a_reg;
            logic [REM-1:0] b_reg;

            if (gi == 0) begin : g_src
               assign a_next = in_a[WIDTH-1:SW];
               assign b_next = in_b[WIDTH-1:SW];
            end else begin : g_src
               assign a_next = g_stage[gi-1].g_skew.a_reg[REM+SW-1:SW];
               assign b_next = g_stage[gi-1].g_skew.b_reg[REM+SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_reg <= '0;
                  b_reg <= '0;
               end else if (advance) begin
                  a_reg <= a_next;
                  b_reg <= b_next;
               end
            end
         end

`ifdef PIPELINED_ADDER_OVF_EN
         if (gi == STAGES - 1) begin : g_ovf
            logic msb_cin;
            logic ovf_reg;

            // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
            assign msb_cin = a_s[SW-1] ^ b_s[SW-1] ^ slice_sum[SW-1];

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  ovf_reg <= 1'b0;
               end else if (advance) begin
                  ovf_reg <= msb_cin ^ slice_sum[SW];
               end
            end
         end
`endif
      end
   endgenerate

   assign out_valid = g_stage[STAGES-1].valid_reg;
   assign out_sum   = g_stage[STAGES-1].sum_reg;
   assign out_cout  = g_stage[STAGES-1].carry_reg;
`ifdef PIPELINED_ADDER_OVF_EN
   assign out_ovf   = g_stage[STAGES-1].g_ovf.ovf_reg;
`endif

   // Safe to be combinational from out_ready because every output is registered.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

endmodule
